answer_input_conditioner: RTL and testbench
===========================================

# answer_input_conditioner

Front-end conditioner between the board's raw push-switches and the quiz game core. It synchronises and debounces the four answer switches and the start button, and produces one-cycle rising-edge pulses. It also delivers a single validated one-hot answer per press through a valid/ack handshake, rejecting multi-switch presses. The game core consumes `answer`, `answer_valid` and `start_pulse` instead of sampling raw switch levels.

## Interface
- `DB_CYCLES`, default 50000: consecutive differing synchronised samples required to accept a level change; legal range 2 to 2^CNT_W-1.
- `CNT_W`, default 16: debounce counter width per channel.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `switch_raw`  in  4  raw answer switches; bit0 '+', bit1 '-', bit2 'x', bit3 '/'.
- `start_raw`  in  1  raw start button.
- `switch_lvl`  out  4  debounced switch levels.
- `switch_pulse`  out  4  one-cycle pulse per bit on a debounced 0->1.
- `start_pulse`  out  1  one-cycle pulse on a debounced start 0->1.
- `answer`  out  4  one-hot accepted answer; meaningful only while `answer_valid`=1.
- `answer_valid`  out  1  accepted answer is pending.
- `answer_ack`  in  1  consumer has taken `answer`.
- `multi_err`  out  1  one-cycle pulse when a press is rejected.

## Operation
- Five identical channels (4 switches plus start). Each channel has a 2-flop synchroniser, a stable flop and a CNT_W counter.
- Counter rule per cycle:
  - If the synchronised value equals the stable value, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DB_CYCLES-1 and the value still differs, the stable value takes the new value and the counter clears.
- A glitch shorter than DB_CYCLES samples never reaches `switch_lvl`.
- The pulse output registers on the same edge the stable value goes 0->1. It lasts exactly one cycle. There is no pulse on 1->0.
- Answer FSM, three states:
  - IDLE: if `switch_pulse`≠0, the FSM checks whether exactly one pulse bit is set and `switch_lvl` is equal to that bit.
    - If so, `answer` <= that bit, `answer_valid` <= 1, go HELD.
    - Otherwise `multi_err` pulses and the FSM goes RELEASE.
  - HELD: `answer_valid`=1 and `answer` frozen.
    - Further pulses are ignored, with no error.
    - On `answer_ack`=1, `answer_valid` <= 0 and the FSM goes RELEASE.
  - RELEASE: wait until `switch_lvl`==0, then go IDLE. Pulses in this state are ignored.
- `start_pulse` in any state forces `answer_valid` <= 0 and state <= RELEASE. It takes priority over a simultaneous `answer_ack` or pulse; the result is the same in both cases.
- `answer` keeps its last value after `answer_valid` drops.

## Timing
- Reset (`reset`=0) takes effect immediately, without waiting for `clk`:
  - all outputs 0;
  - synchronisers, stable flops and counters 0;
  - FSM in IDLE.
- Stable flops reset to 0. A switch held through reset release therefore yields a pulse after the debounce delay and is handled normally.
- Latency: count the first edge that samples the new raw value as edge 1.
  - `switch_lvl`/`switch_pulse`/`start_pulse` update at edge DB_CYCLES+2.
  - `answer_valid` rises at edge DB_CYCLES+3.
  - `multi_err` pulses at edge DB_CYCLES+3.
- Handshake:
  - `answer_ack` is sampled only in HELD.
  - Valid drops on the edge that samples the ack.
  - An ack held across cycles has no further effect.
- Reset mid-debounce discards partial counts. After release, a full DB_CYCLES of agreeing samples is again required.

## Test plan
- Reset: drive `reset`=0 with random `switch_raw` → all outputs 0 immediately. After release with inputs at 0, all outputs stay 0 for 20 cycles.
- Clean press, DB_CYCLES=4: `switch_raw`=0001 held from edge 1 → `switch_lvl[0]`=1 and `switch_pulse`=0001 at edge 6 for one cycle. At edge 7, `answer_valid`=1 and `answer`=0001. `answer_ack` one cycle → valid 0 next edge. Release the switch → IDLE after `switch_lvl` returns 0.
- Bounce, DB_CYCLES=4: raw bit2 pattern 1,1,1,0,1,1,1,1 → no output during the 3-cycle run. Pulse at the 4th consecutive 1 sample (edge 10). One accepted answer only (0100).
- Multi-press: 0011 applied in a single cycle → `multi_err` one cycle at edge 7, `answer_valid` stays 0. Releasing 0011 then pressing 1000 → accepted `answer`=1000.
- Held ignore and start abort: in HELD with `answer`=0001, press bit1 → no change and no error. Then `start_raw` pulse held 6 cycles → `start_pulse` one cycle and `answer_valid` 0 next edge. No answer until all switches are released.
- Mid-operation reset: assert `reset`=0 two cycles into a debounce → no pulse. After release, the still-held switch pulses exactly DB_CYCLES+2 edges later.

Source files
------------

// File: rtl/answer_input_conditioner.sv
// Switch front end for the quiz core: synchronise, debounce and edge-detect four
// answer switches plus start, then hand one validated one-hot answer per press.
module answer_input_conditioner #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switch_raw,
    input  logic       start_raw,
    output logic [3:0] switch_lvl,
    output logic [3:0] switch_pulse,
    output logic       start_pulse,
    output logic [3:0] answer,
    output logic       answer_valid,
    input  logic       answer_ack,
    output logic       multi_err
);

    localparam int unsigned NCH = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    // Channel 4 is start, channels 3..0 are the answer switches.
    logic [NCH-1:0]            raw_all;
    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            stable_q, stable_d;
    logic [NCH-1:0]            pulse_q, pulse_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_e     state_q, state_d;
    logic [3:0] answer_q, answer_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic [3:0] sw_pulse;
    logic [3:0] sw_lvl;
    logic       st_pulse;

    assign raw_all = {start_raw, switch_raw};

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int ch = 0; ch < NCH; ch++) begin
            if (sync2_q[ch] == stable_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                stable_d[ch] = sync2_q[ch];
                cnt_d[ch]    = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
        pulse_d = stable_d & ~stable_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the per-channel counters are plain flops, so resetting them costs nothing and discards partial counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_all;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_pulse = pulse_q[3:0];
    assign st_pulse = pulse_q[4];
    assign sw_lvl   = stable_q[3:0];

    always_comb begin
        state_d  = state_q;
        answer_d = answer_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        if (st_pulse) begin
            // Start aborts any pending answer and waits for a clean release.
            valid_d = 1'b0;
            state_d = ST_RELEASE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (sw_pulse != 4'd0) begin
                        if (((sw_pulse & (sw_pulse - 4'd1)) == 4'd0) && (sw_lvl == sw_pulse)) begin
                            answer_d = sw_pulse;
                            valid_d  = 1'b1;
                            state_d  = ST_HELD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_HELD: begin
                    if (answer_ack) begin
                        valid_d = 1'b0;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (sw_lvl == 4'd0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            answer_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            answer_q <= answer_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign switch_lvl   = sw_lvl;
    assign switch_pulse = sw_pulse;
    assign start_pulse  = st_pulse;
    assign answer       = answer_q;
    assign answer_valid = valid_q;
    assign multi_err    = err_q;

endmodule

// File: tb/tb_answer_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events with their edge numbers,
// an independent monitor pops and compares each event the conditioner produces.
module tb_answer_input_conditioner;

    localparam int unsigned DB = 4;

    typedef enum logic [2:0] {
        EV_PULSE,
        EV_START,
        EV_ERR,
        EV_VUP,
        EV_VDN
    } ev_e;

    typedef struct {
        ev_e         kind;
        logic [3:0]  val;
        int unsigned at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] switch_raw;
    logic       start_raw;
    logic [3:0] switch_lvl;
    logic [3:0] switch_pulse;
    logic       start_pulse;
    logic [3:0] answer;
    logic       answer_valid;
    logic       answer_ack;
    logic       multi_err;

    int unsigned edge_cnt = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    exp_t        exp_q[$];
    logic        prev_valid = 1'b0;
    logic [3:0]  held_ans   = 4'd0;

    answer_input_conditioner #(
        .DB_CYCLES(DB),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .switch_raw  (switch_raw),
        .start_raw   (start_raw),
        .switch_lvl  (switch_lvl),
        .switch_pulse(switch_pulse),
        .start_pulse (start_pulse),
        .answer      (answer),
        .answer_valid(answer_valid),
        .answer_ack  (answer_ack),
        .multi_err   (multi_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    function automatic void expect_ev(input ev_e kind, input logic [3:0] val, input int unsigned at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    task automatic match(input ev_e kind, input logic [3:0] val);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s: got value %0h at edge %0d, expected no event", kind.name(), val, edge_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.at != edge_cnt) begin
                n_err++;
                $display("FAIL event_%s: got %s val %0h at edge %0d, expected %s val %0h at edge %0d",
                         e.kind.name(), kind.name(), val, edge_cnt, e.kind.name(), e.val, e.at);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (switch_pulse != 4'd0) match(EV_PULSE, switch_pulse);
            if (start_pulse)          match(EV_START, 4'd0);
            if (multi_err)            match(EV_ERR, 4'd0);
            if (answer_valid && !prev_valid) begin
                match(EV_VUP, answer);
                held_ans = answer;
            end
            if (!answer_valid && prev_valid) match(EV_VDN, 4'd0);
            if (answer_valid && prev_valid) check("answer_frozen", answer, held_ans);
            prev_valid = answer_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_answer();
        expect_ev(EV_VDN, 4'd0, edge_cnt + 1);
        answer_ack = 1'b1;
        cycles(1);
        answer_ack = 1'b0;
    endtask

    task automatic release_all();
        switch_raw = 4'd0;
        cycles(DB + 3);
        check("lvl_released", switch_lvl, 4'd0);
        cycles(2);
    endtask

    task automatic press_accept(input logic [3:0] sw);
        int unsigned e0;
        e0 = edge_cnt;
        switch_raw = sw;
        expect_ev(EV_PULSE, sw, e0 + DB + 2);
        expect_ev(EV_VUP, sw, e0 + DB + 3);
        cycles(DB + 2);
        check("lvl_at_pulse", switch_lvl, sw);
        cycles(1);
        check("valid_up", answer_valid, 1'b1);
    endtask

    logic [7:0] bounce;

    initial begin
        int unsigned e0;
        rst_n      = 1'b0;
        switch_raw = 4'($urandom);
        start_raw  = 1'($urandom);
        answer_ack = 1'b0;
        #1;
        check("rst_outputs", {switch_lvl, switch_pulse, start_pulse, answer, answer_valid, multi_err}, 15'd0);
        cycles(3);
        check("rst_hold_outputs", {switch_lvl, switch_pulse, start_pulse, answer, answer_valid, multi_err}, 15'd0);
        switch_raw = 4'd0;
        start_raw  = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(20);
        check("idle_20", {switch_lvl, switch_pulse, start_pulse, answer, answer_valid, multi_err}, 15'd0);

        // Clean press, ack, release.
        press_accept(4'b0001);
        ack_answer();
        check("valid_after_ack", answer_valid, 1'b0);
        check("answer_kept", answer, 4'b0001);
        release_all();

        // Bounce on bit2: the 3-sample run is discarded.
        bounce = 8'b1111_0111;
        e0 = edge_cnt;
        expect_ev(EV_PULSE, 4'b0100, e0 + 10);
        expect_ev(EV_VUP, 4'b0100, e0 + 11);
        for (int i = 0; i < 8; i++) begin
            switch_raw = {1'b0, bounce[i], 2'b00};
            if (i == 6) check("bounce_no_lvl", switch_lvl, 4'd0);
            cycles(1);
        end
        cycles(3);
        check("bounce_answer", answer, 4'b0100);
        ack_answer();
        release_all();

        // Simultaneous two-switch press is rejected.
        e0 = edge_cnt;
        switch_raw = 4'b0011;
        expect_ev(EV_PULSE, 4'b0011, e0 + DB + 2);
        expect_ev(EV_ERR, 4'd0, e0 + DB + 3);
        cycles(DB + 5);
        check("multi_no_valid", answer_valid, 1'b0);
        release_all();
        press_accept(4'b1000);
        check("after_multi_answer", answer, 4'b1000);
        ack_answer();
        release_all();

        // Held answer ignores further presses; start aborts it.
        press_accept(4'b0001);
        e0 = edge_cnt;
        switch_raw = 4'b0011;
        expect_ev(EV_PULSE, 4'b0010, e0 + DB + 2);
        cycles(DB + 4);
        check("held_valid", answer_valid, 1'b1);
        check("held_answer", answer, 4'b0001);
        e0 = edge_cnt;
        start_raw = 1'b1;
        expect_ev(EV_START, 4'd0, e0 + DB + 2);
        expect_ev(EV_VDN, 4'd0, e0 + DB + 3);
        cycles(6);
        start_raw = 1'b0;
        cycles(12);
        check("abort_valid", answer_valid, 1'b0);
        check("abort_answer_kept", answer, 4'b0001);
        release_all();
        cycles(4);
        check("no_answer_after_release", answer_valid, 1'b0);

        // Reset two cycles into a debounce discards the partial count.
        switch_raw = 4'b0100;
        cycles(2);
        rst_n = 1'b0;
        cycles(2);
        check("midrst_lvl", switch_lvl, 4'd0);
        e0 = edge_cnt;
        rst_n = 1'b1;
        expect_ev(EV_PULSE, 4'b0100, e0 + DB + 2);
        expect_ev(EV_VUP, 4'b0100, e0 + DB + 3);
        cycles(DB + 3);
        check("midrst_answer", answer, 4'b0100);

        // Asynchronous reset while an answer is pending clears outputs before any edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", answer_valid, 1'b0);
        check("async_rst_answer", answer, 4'd0);
        check("async_rst_lvl", switch_lvl, 4'd0);
        switch_raw = 4'd0;
        cycles(2);
        rst_n = 1'b1;
        cycles(12);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_%s: got no event, expected val %0h at edge %0d", e.kind.name(), e.val, e.at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
